syn_fifo_flex: RTL and testbench
================================

SYN_FIFO_FLEX -- requirements
Module: syn_fifo_flex

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the entry width in bits.
REQ-002 The module SHALL have parameter LOG2_DEPTH, default 8, meaning log2 of the entry count; DEPTH = 2**LOG2_DEPTH.
REQ-003 The module SHALL have parameter FWFT, default 0, meaning read mode: 0 = registered read, 1 = first-word fall-through.
REQ-004 The module SHALL have parameter AF_LVL, default DEPTH-2, meaning the almost-full threshold.
REQ-005 The module SHALL have parameter AE_LVL, default 2, meaning the almost-empty threshold.
REQ-006 The module SHALL use one clock and an asynchronous, active-high reset, with these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of contents
- clr_err  in  1  clears sticky error flags
- data_in  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read/pop request
- data_out  out  DATA_WIDTH  read data
- valid_out  out  1  data_out qualifier
- full, empty  out  1 each  level==DEPTH, level==0
- almost_full, almost_empty  out  1 each  level>=AF_LVL, level<=AE_LVL
- level  out  LOG2_DEPTH+1  current occupancy
- overflow, underflow  out  1 each  sticky error flags

Function
REQ-007 rd_acc SHALL be rd_en & ~empty; wr_acc SHALL be wr_en & (~full | rd_acc), so a write to a full FIFO is accepted when a read is accepted in the same cycle.
REQ-008 Each accepted write SHALL store data_in at wr_ptr, and wr_ptr SHALL advance modulo DEPTH; each accepted read SHALL advance rd_ptr modulo DEPTH (natural wrap).
REQ-009 level SHALL update on the next edge as follows: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither are accepted; it SHALL never exceed DEPTH or go below 0.
REQ-010 The flags full, empty, almost_full and almost_empty SHALL be decoded from registered level only, with no combinational path from wr_en or rd_en.
REQ-011 When FWFT=0, data_out SHALL load the head entry on the edge where rd_acc is true, valid_out SHALL be high for exactly the following cycle, and data_out SHALL hold at all other times.
REQ-012 When FWFT=1, data_out SHALL present the head entry whenever empty=0, valid_out SHALL equal ~empty, and rd_en SHALL pop the head with zero read latency.
REQ-013 When FWFT=1 and a write is made to an empty FIFO, valid_out SHALL assert exactly one cycle after the write edge; there is no same-cycle bypass.
REQ-014 overflow SHALL set on wr_en & ~wr_acc, and underflow SHALL set on rd_en & ~rd_acc; both SHALL stay set until clr_err, and a set in the same cycle as clr_err SHALL win.
REQ-015 flush SHALL zero wr_ptr, rd_ptr, level and data_out on the next edge and SHALL deassert valid_out.
REQ-016 flush SHALL take priority over wr_en and rd_en in the same cycle; those requests SHALL be dropped without setting overflow or underflow.
REQ-017 Memory contents SHALL not be reset or cleared.

Reset
REQ-018 Asserting reset SHALL immediately, without waiting for a clock edge, set wr_ptr=0, rd_ptr=0, level=0, data_out=0, valid_out=0, overflow=0 and underflow=0, giving empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-019 Reset asserted mid-operation SHALL discard all queued entries; the first accepted write after reset release SHALL land at address 0.

Structure
REQ-020 The shared package SHALL hold the read-mode constants (MODE_REG=0, MODE_FWFT=1) and the level-width function (LOG2_DEPTH+1).
REQ-021 The storage SHALL be one sub-module, fifo_dpram: a simple dual-port DEPTH x DATA_WIDTH array with a synchronous write port and an asynchronous read port; all pointers, counters and flags SHALL be in syn_fifo_flex.

Verification (DATA_WIDTH=8, LOG2_DEPTH=2, AF_LVL=3, AE_LVL=1)
REQ-022 Assert reset asynchronously between edges while level=3 -> outputs reach the reset values of REQ-018 before the next edge; a write of 0x5A after release is read back first.
REQ-023 FWFT=0: write 0x11, 0x22, 0x33, 0x44 -> almost_full after the 3rd write, full and level=4 after the 4th; a 5th write of 0x55 -> overflow=1 and level=4; four reads -> 0x11..0x44, each with valid_out one cycle after its rd_en.
REQ-024 From full, wr_en and rd_en together for 3 cycles -> level stays 4, overflow stays 0, and the write and read order is preserved across pointer wrap.
REQ-025 From empty, rd_en -> underflow=1 and level=0; pulse clr_err -> underflow=0; clr_err together with another empty read -> underflow stays 1.
REQ-026 FWFT=1: write 0xA5 to an empty FIFO -> next cycle empty=0, valid_out=1 and data_out=0xA5 with no rd_en; rd_en -> empty=1 on the next edge.
REQ-027 At level=3, flush asserted together with wr_en -> level=0 and empty=1 on the next edge, overflow=0, and the next read after one new write returns the new data.

Source files
------------

// File: rtl/syn_fifo_flex_pkg.sv
// Shared definitions for the flexible synchronous FIFO: read-mode codes and
// the width of the occupancy counter.
package syn_fifo_flex_pkg;

  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit more than the pointers.
  function automatic int level_width(input int log2_depth);
    return log2_depth + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_dpram
  import syn_fifo_flex_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port; contents are deliberately left uninitialised.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_flex.sv
// Single-clock FIFO with selectable registered or first-word fall-through
// read, level-decoded status flags and sticky overflow/underflow flags.
module syn_fifo_flex
  import syn_fifo_flex_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_DEPTH = 8,
  parameter int FWFT       = MODE_REG,
  parameter int AF_LVL     = (2**LOG2_DEPTH) - 2,
  parameter int AE_LVL     = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                clr_err,
  input  logic [DATA_WIDTH-1:0]               data_in,
  input  logic                                wr_en,
  input  logic                                rd_en,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                valid_out,
  output logic                                full,
  output logic                                empty,
  output logic                                almost_full,
  output logic                                almost_empty,
  output logic [level_width(LOG2_DEPTH)-1:0]  level,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int DEPTH = 2**LOG2_DEPTH;
  localparam int LW    = level_width(LOG2_DEPTH);

  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_do;
  logic                  rd_do;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Flush swallows both requests, so nothing moves and no error is raised.
  assign wr_do = wr_acc & ~flush;
  assign rd_do = rd_acc & ~flush;

  // Flags depend only on the registered level, never on the request inputs.
  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LW'(AF_LVL));
  assign almost_empty = (level <= LW'(AE_LVL));

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + 1'b1;
      if (rd_do) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_do, rd_do})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & ~wr_acc & ~flush) | (overflow  & ~clr_err);
      underflow <= (rd_en & ~rd_acc & ~flush) | (underflow & ~clr_err);
    end
  end

  fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (LOG2_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_do),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      // Head is shown as soon as the registered level says it exists; masking
      // with empty keeps uninitialised storage off the output.
      assign data_out  = empty ? '0 : rd_data;
      assign valid_out = ~empty;
    end else begin : g_reg
      // Registered read: capture head on a pop, qualify for one cycle.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_out  <= '0;
          valid_out <= 1'b0;
        end else if (flush) begin
          data_out  <= '0;
          valid_out <= 1'b0;
        end else begin
          if (rd_do) data_out <= rd_data;
          valid_out <= rd_do;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_syn_fifo_flex.sv
// Bench for syn_fifo_flex: one registered-read and one fall-through instance
// share the same stimulus and are compared against a queue-based model.
module tb_syn_fifo_flex;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush, clr_err, wr_en, rd_en;
  logic [7:0] data_in;

  logic [7:0] r_data, f_data;
  logic       r_valid, f_valid;
  logic       r_full, r_empty, r_af, r_ae, r_ov, r_un;
  logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
  logic [2:0] r_level, f_level;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_ov, m_un;
  logic [7:0] m_rdata;
  logic       m_rvalid;

  syn_fifo_flex #(.DATA_WIDTH(8), .LOG2_DEPTH(2), .FWFT(0), .AF_LVL(3), .AE_LVL(1)) u_reg (
    .clk(clk), .reset(reset), .flush(flush), .clr_err(clr_err), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(r_data), .valid_out(r_valid),
    .full(r_full), .empty(r_empty), .almost_full(r_af), .almost_empty(r_ae),
    .level(r_level), .overflow(r_ov), .underflow(r_un));

  syn_fifo_flex #(.DATA_WIDTH(8), .LOG2_DEPTH(2), .FWFT(1), .AF_LVL(3), .AE_LVL(1)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .clr_err(clr_err), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(f_data), .valid_out(f_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .level(f_level), .overflow(f_ov), .underflow(f_un));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("reg.level",  32'(r_level), 32'(n));
    chk("reg.full",   32'(r_full),  32'(n == DEPTH));
    chk("reg.empty",  32'(r_empty), 32'(n == 0));
    chk("reg.af",     32'(r_af),    32'(n >= 3));
    chk("reg.ae",     32'(r_ae),    32'(n <= 1));
    chk("reg.ovf",    32'(r_ov),    32'(m_ov));
    chk("reg.unf",    32'(r_un),    32'(m_un));
    chk("reg.data",   32'(r_data),  32'(m_rdata));
    chk("reg.valid",  32'(r_valid), 32'(m_rvalid));
    chk("fwft.level", 32'(f_level), 32'(n));
    chk("fwft.full",  32'(f_full),  32'(n == DEPTH));
    chk("fwft.empty", 32'(f_empty), 32'(n == 0));
    chk("fwft.ovf",   32'(f_ov),    32'(m_ov));
    chk("fwft.unf",   32'(f_un),    32'(m_un));
    chk("fwft.valid", 32'(f_valid), 32'(n != 0));
    chk("fwft.data",  32'(f_data),  (n != 0) ? 32'(q[0]) : 32'h0);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0; m_un = 1'b0; m_rdata = 8'h00; m_rvalid = 1'b0;
  endtask

  // One clock: drive at negedge, advance the model, check just after posedge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                       input logic fl, input logic ce);
    bit was_full, was_empty, racc, wacc;
    @(negedge clk);
    wr_en = w; data_in = d; rd_en = r; flush = fl; clr_err = ce;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (fl) begin
      q.delete();
      m_rdata = 8'h00; m_rvalid = 1'b0;
      if (ce) begin m_ov = 1'b0; m_un = 1'b0; end
    end else begin
      racc = r && !was_empty;
      wacc = w && (!was_full || racc);
      m_rvalid = racc;
      if (racc) m_rdata = q.pop_front();
      if (wacc) q.push_back(d);
      m_ov = (w && !wacc) || (m_ov && !ce);
      m_un = (r && !racc) || (m_un && !ce);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; flush = 0; clr_err = 0; wr_en = 0; rd_en = 0; data_in = 8'h00;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Fill, overflow, drain in order.
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    cycle(1, 8'h33, 0, 0, 0);
    cycle(1, 8'h44, 0, 0, 0);
    cycle(1, 8'h55, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);

    // Simultaneous write and read while full, across pointer wrap.
    cycle(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 8'hA0 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'hB0 + 8'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);

    // Underflow and its clearing, including set-wins-over-clear.
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 1, 0, 1);
    cycle(0, 8'h00, 0, 0, 1);

    // Fall-through latency on an empty FIFO, then pop.
    cycle(1, 8'hA5, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);

    // Flush at level 3 together with a write.
    cycle(1, 8'h01, 0, 0, 0);
    cycle(1, 8'h02, 0, 0, 0);
    cycle(1, 8'h03, 0, 0, 0);
    cycle(1, 8'h04, 0, 1, 0);
    cycle(1, 8'h77, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);

    // Asynchronous reset between edges at level 3.
    cycle(1, 8'hC1, 0, 0, 0);
    cycle(1, 8'hC2, 0, 0, 0);
    cycle(1, 8'hC3, 0, 0, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
    cycle(1, 8'h5A, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
